// File: rtl/traffic_request_latch.sv
// Per-approach front end for the 4-way traffic controller: synchronise, debounce and
// latch loop-detector hits as pending requests until served, with starvation flags.
module traffic_request_latch #(
  parameter int DEB_CYCLES = 4,
  parameter int MAX_WAIT   = 200,
  parameter int WAIT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sensor_raw,
  input  logic [3:0] green,
  output logic [3:0] traffic_req,
  output logic [3:0] starve,
  output logic [2:0] req_count
);

  localparam int LANES = 4;
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  // Wait counter increments until MAX_WAIT, then sticks there instead of wrapping.
  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v < WAIT_MAX) ? v + WAIT_W'(1) : v;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  logic [3:0]                  sync_p0;
  logic [3:0]                  sync_p1;
  logic [3:0]                  deb_p2;
  logic [3:0][CNT_W-1:0]       cnt_p2;
  logic [3:0]                  req_p3;
  logic [3:0][WAIT_W-1:0]      wcnt_p4;
  logic [3:0]                  starve_p4;

  // Stage 0/1: two-flop synchroniser for the asynchronous loop detectors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= sensor_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage 2: debounce, a level change is accepted after DEB_CYCLES stable samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_p2 <= '0;
      cnt_p2 <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (sync_p1[i] == deb_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_LAST) begin
          deb_p2[i] <= sync_p1[i];
          cnt_p2[i] <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
        end
      end
    end
  end

  // Stage 3: request latch, service (green) wins over a simultaneous detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_p3 <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (green[i]) begin
          req_p3[i] <= 1'b0;
        end else if (deb_p2[i]) begin
          req_p3[i] <= 1'b1;
        end
      end
    end
  end

  // Stage 4: per-lane wait time and starvation flag; both drop as soon as the lane is served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_p4   <= '0;
      starve_p4 <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (!req_p3[i] || green[i]) begin
          wcnt_p4[i]   <= '0;
          starve_p4[i] <= 1'b0;
        end else begin
          wcnt_p4[i]   <= sat_inc(wcnt_p4[i]);
          starve_p4[i] <= (wcnt_p4[i] == WAIT_MAX);
        end
      end
    end
  end

  assign traffic_req = req_p3;
  assign starve      = starve_p4;
  assign req_count   = popcount4(req_p3);

endmodule

// File: tb/tb_traffic_request_latch.sv
// Directed bench for traffic_request_latch with DEB_CYCLES=4, MAX_WAIT=8.
module tb_traffic_request_latch;

  logic       clk;
  logic       rst;
  logic [3:0] sensor_raw;
  logic [3:0] green;
  logic [3:0] traffic_req;
  logic [3:0] starve;
  logic [2:0] req_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  traffic_request_latch #(
    .DEB_CYCLES(4),
    .MAX_WAIT  (8),
    .WAIT_W    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sensor_raw (sensor_raw),
    .green      (green),
    .traffic_req(traffic_req),
    .starve     (starve),
    .req_count  (req_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         rst_first;
    logic [3:0] sensor;
    logic [3:0] grn;
    int         ticks;
    logic [3:0] exp_req;
    logic [3:0] exp_starve;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic check_all(input string name, input logic [3:0] er, input logic [3:0] es,
                           input logic [2:0] ec);
    check({name, ".req"},    {4'h0, traffic_req}, {4'h0, er});
    check({name, ".starve"}, {4'h0, starve},      {4'h0, es});
    check({name, ".count"},  {5'h0, req_count},   {5'h0, ec});
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Asynchronous reset: outputs are checked before any clock edge has occurred.
  task automatic do_reset(input string name);
    #2;
    rst        = 1'b1;
    sensor_raw = 4'b0000;
    green      = 4'b0000;
    #1;
    check_all({name, ".async"}, 4'b0000, 4'b0000, 3'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    rst        = 1'b1;
    sensor_raw = 4'b0000;
    green      = 4'b0000;
    tick(2);
    check_all("por", 4'b0000, 4'b0000, 3'd0);
    rst = 1'b0;
    tick(3);
    check_all("idle", 4'b0000, 4'b0000, 3'd0);

    // T1: reset mid-stream with two requests pending
    sensor_raw = 4'b0101;
    tick(7);
    check_all("t1_set", 4'b0101, 4'b0000, 3'd2);
    do_reset("t1_rst");
    tick(10);
    check_all("t1_stay0", 4'b0000, 4'b0000, 3'd0);

    vq.push_back('{"t2_glitch",      1'b1, 4'b0001, 4'b0000, 3,  4'b0000, 4'b0000, 3'd0});
    vq.push_back('{"t2_glitch_gone", 1'b0, 4'b0000, 4'b0000, 10, 4'b0000, 4'b0000, 3'd0});
    vq.push_back('{"t2_hold6",       1'b0, 4'b0001, 4'b0000, 6,  4'b0000, 4'b0000, 3'd0});
    vq.push_back('{"t2_edge_k6",     1'b0, 4'b0001, 4'b0000, 1,  4'b0001, 4'b0000, 3'd1});
    vq.push_back('{"t3_set",         1'b1, 4'b0100, 4'b0000, 7,  4'b0100, 4'b0000, 3'd1});
    vq.push_back('{"t3_persist",     1'b0, 4'b0000, 4'b0000, 20, 4'b0100, 4'b0100, 3'd1});
    vq.push_back('{"t3_green",       1'b0, 4'b0000, 4'b0100, 1,  4'b0000, 4'b0000, 3'd0});
    vq.push_back('{"t3_stay0",       1'b0, 4'b0000, 4'b0000, 5,  4'b0000, 4'b0000, 3'd0});
    vq.push_back('{"t6_pre",         1'b1, 4'b1111, 4'b0000, 6,  4'b0000, 4'b0000, 3'd0});
    vq.push_back('{"t6_all",         1'b0, 4'b1111, 4'b0000, 1,  4'b1111, 4'b0000, 3'd4});
    vq.push_back('{"t6_serve",       1'b0, 4'b1111, 4'b0101, 1,  4'b1010, 4'b0000, 3'd2});

    for (int v = 0; v < vq.size(); v++) begin
      if (vq[v].rst_first) do_reset({vq[v].name, ".rst"});
      sensor_raw = vq[v].sensor;
      green      = vq[v].grn;
      tick(vq[v].ticks);
      check_all(vq[v].name, vq[v].exp_req, vq[v].exp_starve, vq[v].exp_cnt);
    end

    // T4: green held while the lane is still detecting, then released
    do_reset("t4_rst");
    sensor_raw = 4'b0010;
    tick(7);
    check_all("t4_set", 4'b0010, 4'b0000, 3'd1);
    green = 4'b0010;
    tick(1);
    check_all("t4_clr", 4'b0000, 4'b0000, 3'd0);
    tick(3);
    check_all("t4_held", 4'b0000, 4'b0000, 3'd0);
    green = 4'b0000;
    tick(1);
    check_all("t4_reassert", 4'b0010, 4'b0000, 3'd1);

    // T5: starvation flag timing, saturation and clear
    do_reset("t5_rst");
    sensor_raw = 4'b1000;
    tick(7);
    check_all("t5_set", 4'b1000, 4'b0000, 3'd1);
    tick(8);
    check_all("t5_edge8", 4'b1000, 4'b0000, 3'd1);
    tick(1);
    check_all("t5_edge9", 4'b1000, 4'b1000, 3'd1);
    tick(5);
    check_all("t5_hold", 4'b1000, 4'b1000, 3'd1);
    green = 4'b1000;
    tick(1);
    check_all("t5_green", 4'b0000, 4'b0000, 3'd0);
    green = 4'b0000;
    tick(1);
    check_all("t5_reassert", 4'b1000, 4'b0000, 3'd1);
    do_reset("t5_end");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
